// File: rtl/refr_exec_3stage_if.sv
// Scheduler <-> refresh executor bundle: access/grant/high-priority inputs and
// the registered refresh command plus status flags back.
interface refr_exec_3stage_if #(
  parameter int unsigned NUMRBNK = 4,
  parameter int unsigned BITRBNK = 2,
  parameter int unsigned BITROWS = 3
);
  logic               pacc1;
  logic               pacc2;
  logic               pacc3;
  logic [BITRBNK-1:0] pa1badr;
  logic [BITRBNK-1:0] pa2badr;
  logic [BITRBNK-1:0] pa3badr;
  logic               prefr;
  logic [BITRBNK-1:0] prfbadr;
  logic               phigh;
  logic [BITRBNK-1:0] phibadr;
  logic               norefr;
  logic               rfr_vld;
  logic [BITRBNK-1:0] rfr_badr;
  logic [BITROWS-1:0] rfr_radr;
  logic               rfr_miss;
  logic [NUMRBNK-1:0] rfr_mmask;
  logic               rfr_merr;
  logic               rfr_cerr;
  logic               rfr_serr;

  modport master (
    output pacc1, pacc2, pacc3, pa1badr, pa2badr, pa3badr,
    output prefr, prfbadr, phigh, phibadr,
    input  norefr, rfr_vld, rfr_badr, rfr_radr, rfr_miss, rfr_mmask,
    input  rfr_merr, rfr_cerr, rfr_serr
  );

  modport slave (
    input  pacc1, pacc2, pacc3, pa1badr, pa2badr, pa3badr,
    input  prefr, prfbadr, phigh, phibadr,
    output norefr, rfr_vld, rfr_badr, rfr_radr, rfr_miss, rfr_mmask,
    output rfr_merr, rfr_cerr, rfr_serr
  );
endinterface

// File: rtl/refr_exec_3stage.sv
// Bank-side refresh executor: applies scheduler grants to per-bank row pointers,
// tracks the per-period refresh quota and reports misses, collisions, stuck banks.
module refr_exec_3stage #(
  parameter int unsigned NUMRBNK = 4,
  parameter int unsigned BITRBNK = 2,
  parameter int unsigned NUMROWS = 8,
  parameter int unsigned BITROWS = 3,
  parameter int unsigned REFRPRD = 64,
  parameter int unsigned BITRFPD = 6,
  parameter int unsigned STKMAX  = 16,
  parameter int unsigned BITSTK  = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  refr_exec_3stage_if.slave  bus
);

  logic [BITRFPD-1:0] prd_q,    prd_d;
  logic [NUMRBNK-1:0] pend_q,   pend_d;
  logic [BITROWS-1:0] row_q [NUMRBNK];
  logic [BITROWS-1:0] row_d [NUMRBNK];
  logic               norefr_q, norefr_d;
  logic               vld_q,    vld_d;
  logic [BITRBNK-1:0] badr_q,   badr_d;
  logic [BITROWS-1:0] radr_q,   radr_d;
  logic               miss_q,   miss_d;
  logic [NUMRBNK-1:0] mmask_q,  mmask_d;
  logic               merr_q,   merr_d;
  logic               cerr_q,   cerr_d;
  logic               serr_q,   serr_d;
  logic [BITSTK-1:0]  stk_q,    stk_d;
  logic               hiprv_q,  hiprv_d;
  logic [BITRBNK-1:0] hibadr_q, hibadr_d;

  logic [NUMRBNK-1:0] sel_c;
  logic [NUMRBNK-1:0] gmask_c;
  logic [NUMRBNK-1:0] pend_post_c;
  logic               gnt_c;
  logic               wrap_c;
  logic               coll_c;
  logic               same_c;

  // Next-state: grant decode, quota bookkeeping, error monitors
  always_comb begin
    sel_c       = '0;
    radr_d      = radr_q;
    badr_d      = badr_q;
    row_d       = row_q;
    for (int unsigned b = 0; b < NUMRBNK; b++) begin
      sel_c[b] = (bus.prfbadr == BITRBNK'(b));
    end
    gnt_c       = bus.prefr && (|sel_c);
    gmask_c     = gnt_c ? sel_c : '0;
    pend_post_c = pend_q & ~gmask_c;
    wrap_c      = (prd_q == BITRFPD'(REFRPRD - 1));

    for (int unsigned b = 0; b < NUMRBNK; b++) begin
      if (gmask_c[b]) begin
        radr_d   = row_q[b];
        row_d[b] = (row_q[b] == BITROWS'(NUMROWS - 1)) ? '0 : row_q[b] + BITROWS'(1);
      end
    end
    if (gnt_c) begin
      badr_d = bus.prfbadr;
    end
    vld_d = gnt_c;

    prd_d    = wrap_c ? '0 : prd_q + BITRFPD'(1);
    pend_d   = wrap_c ? '1 : pend_post_c;
    miss_d   = wrap_c && (|pend_post_c);
    mmask_d  = miss_d ? pend_post_c : '0;
    norefr_d = (pend_d == '0);
    merr_d   = merr_q | miss_d;

    coll_c = bus.prefr && ((bus.pacc1 && (bus.pa1badr == bus.prfbadr)) ||
                           (bus.pacc2 && (bus.pa2badr == bus.prfbadr)) ||
                           (bus.pacc3 && (bus.pa3badr == bus.prfbadr)));
    cerr_d = cerr_q | coll_c | (bus.prefr && !(|sel_c));

    // Run length counts cycles spent on one bank, so the first cycle counts as 1
    same_c   = bus.phigh && hiprv_q && (bus.phibadr == hibadr_q);
    if (!bus.phigh) begin
      stk_d = '0;
    end else if (!same_c) begin
      stk_d = BITSTK'(1);
    end else if (stk_q == BITSTK'(STKMAX)) begin
      stk_d = stk_q;
    end else begin
      stk_d = stk_q + BITSTK'(1);
    end
    serr_d   = serr_q | (stk_d == BITSTK'(STKMAX));
    hiprv_d  = bus.phigh;
    hibadr_d = bus.phibadr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prd_q    <= '0;
      pend_q   <= '1;
      for (int unsigned b = 0; b < NUMRBNK; b++) begin
        row_q[b] <= '0;
      end
      norefr_q <= 1'b0;
      vld_q    <= 1'b0;
      badr_q   <= '0;
      radr_q   <= '0;
      miss_q   <= 1'b0;
      mmask_q  <= '0;
      merr_q   <= 1'b0;
      cerr_q   <= 1'b0;
      serr_q   <= 1'b0;
      stk_q    <= '0;
      hiprv_q  <= 1'b0;
      hibadr_q <= '0;
    end else begin
      prd_q    <= prd_d;
      pend_q   <= pend_d;
      row_q    <= row_d;
      norefr_q <= norefr_d;
      vld_q    <= vld_d;
      badr_q   <= badr_d;
      radr_q   <= radr_d;
      miss_q   <= miss_d;
      mmask_q  <= mmask_d;
      merr_q   <= merr_d;
      cerr_q   <= cerr_d;
      serr_q   <= serr_d;
      stk_q    <= stk_d;
      hiprv_q  <= hiprv_d;
      hibadr_q <= hibadr_d;
    end
  end

  assign bus.norefr    = norefr_q;
  assign bus.rfr_vld   = vld_q;
  assign bus.rfr_badr  = badr_q;
  assign bus.rfr_radr  = radr_q;
  assign bus.rfr_miss  = miss_q;
  assign bus.rfr_mmask = mmask_q;
  assign bus.rfr_merr  = merr_q;
  assign bus.rfr_cerr  = cerr_q;
  assign bus.rfr_serr  = serr_q;

endmodule
